mrv_sram_arbiter: RTL and testbench
===================================

// Module: mrv_sram_arbiter
// PURPOSE
//  Merges the CPU instruction (imem_*) and data (dmem_*) SRAM-style ports onto one
//  shared single-port SRAM (s_*). Sits directly downstream of mrv_cpu. Round-robin or
//  fixed-priority arbitration, grant lock across memory stalls, one-cycle response
//  routing and an address-range check answered locally with an error.
// PARAMETERS
//  FAIR      1            1: round-robin; 0: fixed priority, dmem wins
//  MEM_BASE  32'h0000_0000  lowest legal byte address (inclusive)
//  MEM_SIZE  32'h0001_0000  legal window size in bytes; legal = MEM_BASE <= addr < MEM_BASE+MEM_SIZE
// PORTS
//  g_clk                  in   1   global clock, rising edge
//  g_reset                in   1   asynchronous, active-high reset
//  imem_cen / dmem_cen    in   1   master request valid
//  imem_wen / dmem_wen    in   1   write (1) / read (0)
//  imem_strb / dmem_strb  in   4   byte write strobes
//  imem_addr / dmem_addr  in   32  byte address
//  imem_wdata/ dmem_wdata in   32  write data
//  imem_stall/ dmem_stall out  1   request not accepted this cycle
//  imem_rdata/ dmem_rdata out  32  read data, valid cycle after accept
//  imem_error/ dmem_error out  1   response error, valid cycle after accept
//  s_cen s_wen            out  1   shared SRAM request / write
//  s_strb                 out  4   shared SRAM strobes
//  s_addr s_wdata         out  32  shared SRAM address / write data
//  s_stall                in   1   SRAM not accepting this cycle
//  s_rdata                in   32  SRAM read data, cycle after accept
//  s_error                in   1   SRAM error, cycle after accept
// BEHAVIOUR
//  Protocol (both sides): accept = cen & !stall; rdata/error valid exactly 1 cycle later.
//  State regs: last_q (last granted master; reset = IMEM), lock_q/lock_own_q,
//   rsp_vld_q, rsp_own_q, rsp_oor_q. All cleared asynchronously by g_reset.
//  Reset values: s_cen=0, imem/dmem_stall=1, all rdata=0, all error=0.
//  Grant (combinational): lock_q ? lock_own_q : single requester, else both ->
//   FAIR=1: master != last_q; FAIR=0: dmem.
//  Granted, in range: s_* = granted master's wen/strb/addr/wdata, s_cen=1,
//   granted stall = s_stall. Loser: stall=1, nothing forwarded.
//  Granted, out of range: s_cen=0, granted stall=0 (accepted locally).
//  No cen: that master's stall=0. No grant: s_cen=0, s_* payload = 0.
//  Lock: set when granted in-range request sees s_stall=1; holds grant until accept;
//   cleared on accept. Master must hold request stable while stalled.
//  On any accept: last_q<=granted, rsp_vld_q<=1, rsp_own_q<=granted,
//   rsp_oor_q<=out-of-range; else rsp_vld_q<=0.
//  Response cycle (rsp_vld_q): owner rdata = rsp_oor_q ? 0 : s_rdata;
//   owner error = rsp_oor_q | s_error. Non-owner rdata=0, error=0. Writes also respond.
//  Back-to-back: accept and response delivery in same cycle are independent
//   (full throughput, 1 access/cycle).
//  Range check: 33-bit compare, MEM_BASE+MEM_SIZE may equal 2^32 with no wrap error.
//  Reset mid-operation: lock and outstanding response dropped; no error emitted.
// TESTING
//  1 FAIR=1, after reset imem+dmem cen=1, s_stall=0 -> cyc0 dmem accepted,
//    imem_stall=1; cyc1 imem accepted, dmem_rdata = s_rdata; cyc2 imem_rdata = s_rdata.
//  2 imem read granted, s_stall=1 for 3 cycles, dmem_cen raised at cyc1 -> s_addr stays
//    imem_addr, dmem_stall=1 cycles 1-3; dmem accepted cyc4.
//  3 dmem read addr 32'h2000_0000 (defaults) -> s_cen=0, dmem_stall=0;
//    next cycle dmem_error=1, dmem_rdata=0.
//  4 dmem write strb=4'b0011 in range, s_error=1 on response cycle -> s_strb=4'b0011,
//    dmem_error=1 one cycle after accept, imem_error=0.
//  5 g_reset pulsed mid-lock (no clock edge) -> s_cen=0, both stall=1 immediately;
//    after release, imem cen alone accepted on first cycle with s_stall=0.
//  6 FAIR=0, both cen continuous, s_stall=0 for 4 cycles -> dmem accepted every
//    cycle, imem_stall=1 throughout.

Source files
------------

// File: rtl/mrv_sram_arbiter_if.sv
// Single-port SRAM-style bus: request (cen/wen/strb/addr/wdata) one way,
// stall plus next-cycle response (rdata/error) the other way.
interface mrv_sram_arbiter_if;
  logic        cen;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        error;

  // Requester side of the bus
  modport master (
    output cen, wen, strb, addr, wdata,
    input  stall, rdata, error
  );

  // Responder side of the bus
  modport slave (
    input  cen, wen, strb, addr, wdata,
    output stall, rdata, error
  );
endinterface

// File: rtl/mrv_sram_arbiter.sv
// Merges the CPU instruction and data SRAM ports onto one shared SRAM.
// Round-robin or fixed-priority (dmem wins) arbitration, grant lock while the
// SRAM stalls a granted request, one-cycle response routing, and an address
// window check answered locally with an error response.
module mrv_sram_arbiter #(
  parameter bit          FAIR     = 1'b1,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0001_0000
) (
  input  logic               g_clk,
  input  logic               g_reset,
  mrv_sram_arbiter_if.slave  imem,
  mrv_sram_arbiter_if.slave  dmem,
  mrv_sram_arbiter_if.master s
);

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

  // Legal window check done in 33 bits so MEM_BASE+MEM_SIZE may reach 2^32.
  function automatic logic in_range(input logic [31:0] addr);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, MEM_BASE};
    hi = lo + {1'b0, MEM_SIZE};
    return (a >= lo) && (a < hi);
  endfunction

  owner_e last_q;
  logic   lock_q;
  owner_e lock_own_q;
  logic   rsp_vld_q;
  owner_e rsp_own_q;
  logic   rsp_oor_q;

  logic        gnt_vld_s;
  owner_e      gnt_own_s;
  logic        sel_wen_s;
  logic [3:0]  sel_strb_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        gnt_inr_s;
  logic        accept_s;

  // Grant selection: a held lock wins, then a single requester, then the policy.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_own_s = OWN_IMEM;
    if (lock_q) begin
      gnt_own_s = lock_own_q;
      gnt_vld_s = (lock_own_q == OWN_DMEM) ? dmem.cen : imem.cen;
    end else if (imem.cen && dmem.cen) begin
      gnt_vld_s = 1'b1;
      if (FAIR) begin
        gnt_own_s = (last_q == OWN_IMEM) ? OWN_DMEM : OWN_IMEM;
      end else begin
        gnt_own_s = OWN_DMEM;
      end
    end else if (dmem.cen) begin
      gnt_vld_s = 1'b1;
      gnt_own_s = OWN_DMEM;
    end else if (imem.cen) begin
      gnt_vld_s = 1'b1;
      gnt_own_s = OWN_IMEM;
    end else begin
      gnt_vld_s = 1'b0;
      gnt_own_s = OWN_IMEM;
    end
  end

  // Payload of the granted master, its range check and the accept condition.
  always_comb begin
    sel_wen_s   = 1'b0;
    sel_strb_s  = 4'b0000;
    sel_addr_s  = 32'h0000_0000;
    sel_wdata_s = 32'h0000_0000;
    if (gnt_own_s == OWN_DMEM) begin
      sel_wen_s   = dmem.wen;
      sel_strb_s  = dmem.strb;
      sel_addr_s  = dmem.addr;
      sel_wdata_s = dmem.wdata;
    end else begin
      sel_wen_s   = imem.wen;
      sel_strb_s  = imem.strb;
      sel_addr_s  = imem.addr;
      sel_wdata_s = imem.wdata;
    end
    gnt_inr_s = in_range(sel_addr_s);
    // Out-of-range requests are accepted locally regardless of s.stall.
    accept_s  = gnt_vld_s && (gnt_inr_s ? !s.stall : 1'b1);
  end

  // Shared SRAM request: forward only a granted in-range request outside reset.
  always_comb begin
    s.cen   = 1'b0;
    s.wen   = 1'b0;
    s.strb  = 4'b0000;
    s.addr  = 32'h0000_0000;
    s.wdata = 32'h0000_0000;
    if (!g_reset && gnt_vld_s && gnt_inr_s) begin
      s.cen   = 1'b1;
      s.wen   = sel_wen_s;
      s.strb  = sel_strb_s;
      s.addr  = sel_addr_s;
      s.wdata = sel_wdata_s;
    end else begin
      s.cen   = 1'b0;
    end
  end

  // Master stalls: idle masters never stall, losers always stall, the winner
  // sees the SRAM stall (or none when answered locally). Reset stalls both.
  always_comb begin
    imem.stall = 1'b1;
    dmem.stall = 1'b1;
    if (g_reset) begin
      imem.stall = 1'b1;
      dmem.stall = 1'b1;
    end else begin
      if (!imem.cen) begin
        imem.stall = 1'b0;
      end else if (gnt_vld_s && (gnt_own_s == OWN_IMEM)) begin
        imem.stall = gnt_inr_s ? s.stall : 1'b0;
      end else begin
        imem.stall = 1'b1;
      end
      if (!dmem.cen) begin
        dmem.stall = 1'b0;
      end else if (gnt_vld_s && (gnt_own_s == OWN_DMEM)) begin
        dmem.stall = gnt_inr_s ? s.stall : 1'b0;
      end else begin
        dmem.stall = 1'b1;
      end
    end
  end

  // Response routing to the owner of the access accepted last cycle.
  always_comb begin
    imem.rdata = 32'h0000_0000;
    imem.error = 1'b0;
    dmem.rdata = 32'h0000_0000;
    dmem.error = 1'b0;
    if (rsp_vld_q && (rsp_own_q == OWN_IMEM)) begin
      imem.rdata = rsp_oor_q ? 32'h0000_0000 : s.rdata;
      imem.error = rsp_oor_q | s.error;
    end else if (rsp_vld_q && (rsp_own_q == OWN_DMEM)) begin
      dmem.rdata = rsp_oor_q ? 32'h0000_0000 : s.rdata;
      dmem.error = rsp_oor_q | s.error;
    end else begin
      imem.rdata = 32'h0000_0000;
      dmem.rdata = 32'h0000_0000;
    end
  end

  // Arbitration history, grant lock and outstanding response tracking.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      last_q     <= OWN_IMEM;
      lock_q     <= 1'b0;
      lock_own_q <= OWN_IMEM;
      rsp_vld_q  <= 1'b0;
      rsp_own_q  <= OWN_IMEM;
      rsp_oor_q  <= 1'b0;
    end else begin
      if (accept_s) begin
        last_q    <= gnt_own_s;
        rsp_vld_q <= 1'b1;
        rsp_own_q <= gnt_own_s;
        rsp_oor_q <= !gnt_inr_s;
        lock_q    <= 1'b0;
      end else begin
        rsp_vld_q <= 1'b0;
        if (gnt_vld_s && gnt_inr_s && s.stall) begin
          lock_q     <= 1'b1;
          lock_own_q <= gnt_own_s;
        end else begin
          lock_q     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mrv_sram_arbiter.sv
// Scoreboard bench for mrv_sram_arbiter: one round-robin and one
// fixed-priority instance, directed per-cycle vectors, expected outputs queued
// by the stimulus and compared by a negedge monitor.
module tb_mrv_sram_arbiter;

  logic clk;
  logic g_reset;

  mrv_sram_arbiter_if rr_imem ();
  mrv_sram_arbiter_if rr_dmem ();
  mrv_sram_arbiter_if rr_s ();
  mrv_sram_arbiter_if fp_imem ();
  mrv_sram_arbiter_if fp_dmem ();
  mrv_sram_arbiter_if fp_s ();

  mrv_sram_arbiter #(.FAIR(1'b1)) dut_rr (
    .g_clk(clk), .g_reset(g_reset), .imem(rr_imem), .dmem(rr_dmem), .s(rr_s)
  );

  mrv_sram_arbiter #(.FAIR(1'b0)) dut_fp (
    .g_clk(clk), .g_reset(g_reset), .imem(fp_imem), .dmem(fp_dmem), .s(fp_s)
  );

  typedef struct {
    int          id;
    bit          fp;
    logic        scen;
    logic        swen;
    logic [3:0]  sstrb;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic        ist;
    logic        dst;
    logic [31:0] ird;
    logic        ier;
    logic [31:0] drd;
    logic        der;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vid      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input bit fp, input logic cen, input logic wen, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (fp) begin
      fp_imem.cen = cen; fp_imem.wen = wen; fp_imem.strb = strb;
      fp_imem.addr = addr; fp_imem.wdata = wdata;
    end else begin
      rr_imem.cen = cen; rr_imem.wen = wen; rr_imem.strb = strb;
      rr_imem.addr = addr; rr_imem.wdata = wdata;
    end
  endtask

  task automatic set_d(input bit fp, input logic cen, input logic wen, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (fp) begin
      fp_dmem.cen = cen; fp_dmem.wen = wen; fp_dmem.strb = strb;
      fp_dmem.addr = addr; fp_dmem.wdata = wdata;
    end else begin
      rr_dmem.cen = cen; rr_dmem.wen = wen; rr_dmem.strb = strb;
      rr_dmem.addr = addr; rr_dmem.wdata = wdata;
    end
  endtask

  task automatic set_s(input bit fp, input logic stall, input logic [31:0] rdata, input logic err);
    if (fp) begin
      fp_s.stall = stall; fp_s.rdata = rdata; fp_s.error = err;
    end else begin
      rr_s.stall = stall; rr_s.rdata = rdata; rr_s.error = err;
    end
  endtask

  task automatic expect_v(input bit fp, input logic scen, input logic swen, input logic [3:0] sstrb,
                          input logic [31:0] saddr, input logic [31:0] swdata,
                          input logic ist, input logic dst,
                          input logic [31:0] ird, input logic ier,
                          input logic [31:0] drd, input logic der);
    exp_t e;
    e.id = vid; e.fp = fp; e.scen = scen; e.swen = swen; e.sstrb = sstrb;
    e.saddr = saddr; e.swdata = swdata; e.ist = ist; e.dst = dst;
    e.ird = ird; e.ier = ier; e.drd = drd; e.der = der;
    q.push_back(e);
    vid++;
  endtask

  task automatic chk(input int id, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d %s actual=%h required=%h", id, f, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic        a_scen, a_swen, a_ist, a_dst, a_ier, a_der;
      logic [3:0]  a_sstrb;
      logic [31:0] a_saddr, a_swdata, a_ird, a_drd;
      e = q.pop_front();
      if (e.fp) begin
        a_scen = fp_s.cen; a_swen = fp_s.wen; a_sstrb = fp_s.strb;
        a_saddr = fp_s.addr; a_swdata = fp_s.wdata;
        a_ist = fp_imem.stall; a_dst = fp_dmem.stall;
        a_ird = fp_imem.rdata; a_ier = fp_imem.error;
        a_drd = fp_dmem.rdata; a_der = fp_dmem.error;
      end else begin
        a_scen = rr_s.cen; a_swen = rr_s.wen; a_sstrb = rr_s.strb;
        a_saddr = rr_s.addr; a_swdata = rr_s.wdata;
        a_ist = rr_imem.stall; a_dst = rr_dmem.stall;
        a_ird = rr_imem.rdata; a_ier = rr_imem.error;
        a_drd = rr_dmem.rdata; a_der = rr_dmem.error;
      end
      chk(e.id, "s_cen",      {31'd0, a_scen},  {31'd0, e.scen});
      chk(e.id, "s_wen",      {31'd0, a_swen},  {31'd0, e.swen});
      chk(e.id, "s_strb",     {28'd0, a_sstrb}, {28'd0, e.sstrb});
      chk(e.id, "s_addr",     a_saddr,          e.saddr);
      chk(e.id, "s_wdata",    a_swdata,         e.swdata);
      chk(e.id, "imem_stall", {31'd0, a_ist},   {31'd0, e.ist});
      chk(e.id, "dmem_stall", {31'd0, a_dst},   {31'd0, e.dst});
      chk(e.id, "imem_rdata", a_ird,            e.ird);
      chk(e.id, "imem_error", {31'd0, a_ier},   {31'd0, e.ier});
      chk(e.id, "dmem_rdata", a_drd,            e.drd);
      chk(e.id, "dmem_error", {31'd0, a_der},   {31'd0, e.der});
    end
  end

  initial begin
    g_reset = 1'b1;
    for (int f = 0; f < 2; f++) begin
      set_i(f[0], 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_d(f[0], 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_s(f[0], 1'b0, 32'h0, 1'b0);
    end
    // Reset state, with a request pending on imem.
    tick();
    set_i(1'b0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    expect_v(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_v(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

    // Round-robin: dmem first after reset, then imem.
    tick();
    g_reset = 1'b0;
    set_d(1'b0, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
    expect_v(1'b0, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    set_s(1'b0, 1'b0, 32'h1111_2222, 1'b0);
    expect_v(1'b0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h1111_2222, 1'b0);
    tick();
    set_i(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_s(1'b0, 1'b0, 32'h3333_4444, 1'b0);
    expect_v(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3333_4444, 1'b0, 32'h0, 1'b0);

    // Out-of-range dmem read answered locally even with the SRAM stalling.
    tick();
    set_d(1'b0, 1'b1, 1'b0, 4'h0, 32'h2000_0000, 32'h0);
    set_s(1'b0, 1'b1, 32'h0, 1'b0);
    expect_v(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_s(1'b0, 1'b0, 32'h5555_6666, 1'b0);
    expect_v(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Window boundary: first byte past the end is illegal, last word is legal.
    tick();
    set_i(1'b0, 1'b1, 1'b0, 4'h0, 32'h0001_0000, 32'h0);
    expect_v(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    set_i(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_FFFC, 32'h0);
    set_s(1'b0, 1'b0, 32'h7777_8888, 1'b0);
    expect_v(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_FFFC, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    tick();
    set_i(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_s(1'b0, 1'b0, 32'h9999_AAAA, 1'b0);
    expect_v(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h9999_AAAA, 1'b0, 32'h0, 1'b0);

    // dmem byte write, SRAM error on the response cycle.
    tick();
    set_d(1'b0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hCAFE_0011);
    expect_v(1'b0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hCAFE_0011, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_s(1'b0, 1'b0, 32'hBBBB_CCCC, 1'b1);
    expect_v(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hBBBB_CCCC, 1'b1);

    // Grant lock: imem stalled 3 cycles, dmem arrives and must wait.
    tick();
    set_i(1'b0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
    set_s(1'b0, 1'b1, 32'h0, 1'b0);
    expect_v(1'b0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    set_d(1'b0, 1'b1, 1'b0, 4'h0, 32'h90, 32'h0);
    expect_v(1'b0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    expect_v(1'b0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    set_s(1'b0, 1'b0, 32'h0, 1'b0);
    expect_v(1'b0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    set_i(1'b0, 1'b1, 1'b0, 4'h0, 32'h84, 32'h0);
    set_s(1'b0, 1'b0, 32'h1234_5678, 1'b0);
    expect_v(1'b0, 1'b1, 1'b0, 4'h0, 32'h90, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    tick();
    set_i(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_s(1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
    expect_v(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0);

    // Reset pulse between clock edges while a lock is held.
    tick();
    set_i(1'b0, 1'b1, 1'b0, 4'h0, 32'hC0, 32'h0);
    set_s(1'b0, 1'b1, 32'h0, 1'b0);
    expect_v(1'b0, 1'b1, 1'b0, 4'h0, 32'hC0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    g_reset = 1'b1;
    expect_v(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_v(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    #7;
    g_reset = 1'b0;
    set_i(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_s(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    set_i(1'b0, 1'b1, 1'b0, 4'h0, 32'hC0, 32'h0);
    set_s(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    expect_v(1'b0, 1'b1, 1'b0, 4'h0, 32'hC0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    set_i(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_s(1'b0, 1'b0, 32'h2468_ACE0, 1'b0);
    expect_v(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h2468_ACE0, 1'b0, 32'h0, 1'b0);

    // Fixed priority: dmem wins every cycle while both request.
    for (int k = 0; k < 4; k++) begin
      tick();
      set_i(1'b1, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      set_d(1'b1, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      set_s(1'b1, 1'b0, 32'h1000_0000 + 32'(k), 1'b0);
      expect_v(1'b1, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
               (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k), 1'b0);
    end
    tick();
    set_i(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_s(1'b1, 1'b0, 32'h1000_0004, 1'b0);
    expect_v(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h1000_0004, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
